// File: rtl/br_pkg.sv
// Shared definitions for the branch sequencer: FSM encoding, condition bit
// positions in the one-hot br_cond vector, and datapath widths.
package br_pkg;

  localparam int DATA_W    = 32;
  localparam int BR_COND_W = 6;

  localparam int BR_EQ  = 0;
  localparam int BR_NE  = 1;
  localparam int BR_GEZ = 2;
  localparam int BR_GTZ = 3;
  localparam int BR_LEZ = 4;
  localparam int BR_LTZ = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_DS = 2'd1,
    REDIR   = 2'd2
  } br_state_e;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational MIPS branch condition evaluation: builds the condition
// vector from the forwarded operands and ORs the bits selected by cond.
module br_cond_eval
  import br_pkg::*;
(
  input  logic [DATA_W-1:0]    rs,
  input  logic [DATA_W-1:0]    rt,
  input  logic [BR_COND_W-1:0] cond,
  output logic                 taken
);

  logic                 rs_neg;
  logic                 rs_zero;
  logic [BR_COND_W-1:0] cond_vec;

  assign rs_neg  = rs[DATA_W-1];
  assign rs_zero = (rs == '0);

  always_comb begin
    cond_vec         = '0;
    cond_vec[BR_EQ]  = (rs == rt);
    cond_vec[BR_NE]  = (rs != rt);
    cond_vec[BR_GEZ] = ~rs_neg;
    cond_vec[BR_GTZ] = ~rs_neg & ~rs_zero;
    cond_vec[BR_LEZ] = rs_neg | rs_zero;
    cond_vec[BR_LTZ] = rs_neg;
  end

  // An all-zero cond selects nothing, so the branch is never taken.
  assign taken = |(cond_vec & cond);

endmodule

// File: rtl/br_seq.sv
// Branch sequencer between decode and fetch: resolves branches, waits for the
// delay slot, then issues a one-shot redirect and fetch kill.
//
// Redirect handshake: redir_valid/redir_pc/fetch_kill are registered and held
// stable while redir_valid=1; the transfer happens on a clock edge where
// redir_valid & redir_ready are both high (and ex_flush is low), after which
// the outputs drop on the following cycle.
module br_seq
  import br_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 br_valid,
  input  logic [DATA_W-1:0]    br_rs,
  input  logic [DATA_W-1:0]    br_rt,
  input  logic [BR_COND_W-1:0] br_cond,
  input  logic [ADDR_W-1:0]    br_target,
  input  logic                 ds_valid,
  input  logic                 stall,
  input  logic                 ex_flush,
  input  logic                 redir_ready,
  output logic                 br_busy,
  output logic                 redir_valid,
  output logic [ADDR_W-1:0]    redir_pc,
  output logic                 fetch_kill,
  output logic                 ds_br_err,
  output logic [CNT_W-1:0]     perf_br,
  output logic [CNT_W-1:0]     perf_taken,
  output logic [1:0]           dbg_state
);

  br_state_e         state_q, state_d;
  logic [ADDR_W-1:0] target_q;
  logic              taken;
  logic              acc_br, acc_ds;
  logic              load_tgt;
  logic              inc_br, inc_taken;
  logic              err_d;

  br_cond_eval u_cond (
    .rs    (br_rs),
    .rt    (br_rt),
    .cond  (br_cond),
    .taken (taken)
  );

  assign acc_br = br_valid & ~stall & ~ex_flush;
  assign acc_ds = ds_valid & ~stall & ~ex_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_tgt  = 1'b0;
    inc_br    = 1'b0;
    inc_taken = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc_br) begin
          inc_br = 1'b1;
          if (taken) begin
            inc_taken = 1'b1;
            load_tgt  = 1'b1;
            state_d   = WAIT_DS;
          end
        end
      end
      WAIT_DS: begin
        // A branch riding with the delay slot is an error, not a new branch.
        if (acc_ds) begin
          state_d = REDIR;
          err_d   = br_valid;
        end
      end
      REDIR: begin
        if (redir_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (ex_flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           target_q <= '0;
    else if (ex_flush) target_q <= '0;
    else if (load_tgt) target_q <= br_target;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redir_valid <= 1'b0;
      fetch_kill  <= 1'b0;
      redir_pc    <= '0;
      ds_br_err   <= 1'b0;
    end else begin
      redir_valid <= (state_d == REDIR);
      fetch_kill  <= (state_d == REDIR);
      redir_pc    <= (state_d == REDIR) ? target_q : '0;
      ds_br_err   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br    <= '0;
      perf_taken <= '0;
    end else begin
      if (inc_br)    perf_br    <= perf_br + 1'b1;
      if (inc_taken) perf_taken <= perf_taken + 1'b1;
    end
  end

  assign br_busy   = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_br_seq.sv
// Bench for br_seq: directed and randomized branches, scoreboard of expected
// redirect targets popped by an independent redirect monitor.
module tb_br_seq;

  logic        clk, rst;
  logic        br_valid;
  logic [31:0] br_rs, br_rt;
  logic [5:0]  br_cond;
  logic [31:0] br_target;
  logic        ds_valid, stall, ex_flush, redir_ready;
  logic        br_busy, redir_valid, fetch_kill, ds_br_err;
  logic [31:0] redir_pc, perf_br, perf_taken;
  logic [1:0]  dbg_state;

  br_seq #(.ADDR_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_rs(br_rs), .br_rt(br_rt),
    .br_cond(br_cond), .br_target(br_target), .ds_valid(ds_valid), .stall(stall),
    .ex_flush(ex_flush), .redir_ready(redir_ready), .br_busy(br_busy),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .fetch_kill(fetch_kill),
    .ds_br_err(ds_br_err), .perf_br(perf_br), .perf_taken(perf_taken),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int exp_br = 0, exp_taken = 0, exp_err = 0, err_seen = 0;
  logic        prev_hold = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc = '0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Reference: MIPS branch rules written directly with signed arithmetic.
  function automatic bit ref_taken(input logic [31:0] rs, input logic [31:0] rt, input logic [5:0] c);
    int signed s;
    s = $signed(rs);
    return (c[0] && rs == rt) || (c[1] && rs != rt) || (c[2] && s >= 0) ||
           (c[3] && s > 0) || (c[4] && s <= 0) || (c[5] && s < 0);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_hold  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (ds_br_err) err_seen++;
      if (prev_hold) begin
        check("redir_hold_valid", 32'(redir_valid), 1);
        check("redir_hold_pc", redir_pc, prev_pc);
      end
      if (redir_valid && !prev_valid)
        check("redir_expected", 32'(exp_q.size() != 0), 1);
      if (redir_valid && (redir_ready || ex_flush)) begin
        if (exp_q.size() == 0) check("redir_unexpected_pop", 0, 1);
        else check("redir_pc_sb", redir_pc, exp_q.pop_front());
      end
      prev_hold  = redir_valid && !redir_ready && !ex_flush;
      prev_valid = redir_valid;
      prev_pc    = redir_pc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 normal, 1 flush in WAIT_DS, 2 flush in REDIR, 3 branch in delay slot
  task automatic run_branch(input logic [31:0] rs, input logic [31:0] rt, input logic [5:0] cond,
                            input logic [31:0] tgt, input int ds_stall, input int rdy_lat,
                            input int mode);
    bit tk;
    tk = ref_taken(rs, rt, cond);
    br_valid = 1'b1; br_rs = rs; br_rt = rt; br_cond = cond; br_target = tgt;
    exp_br++;
    if (tk) exp_taken++;
    step();
    br_valid = 1'b0;
    if (!tk) begin
      check("nt_busy", 32'(br_busy), 0);
      check("nt_redir", 32'(redir_valid), 0);
      return;
    end
    check("tk_busy", 32'(br_busy), 1);
    check("tk_no_redir_yet", 32'(redir_valid), 0);
    ds_valid = 1'b1;
    if (mode == 1) begin
      ex_flush = 1'b1;
      step();
      ex_flush = 1'b0; ds_valid = 1'b0;
      check("flush_ds_busy", 32'(br_busy), 0);
      check("flush_ds_redir", 32'(redir_valid), 0);
      return;
    end
    stall = 1'b1;
    for (int i = 0; i < ds_stall; i++) begin
      step();
      check("stall_busy", 32'(br_busy), 1);
      check("stall_redir", 32'(redir_valid), 0);
    end
    stall = 1'b0;
    if (mode == 3) begin
      br_valid = 1'b1; br_target = ~tgt; br_cond = 6'b111111;
      exp_err++;
    end
    exp_q.push_back(tgt);
    step();
    ds_valid = 1'b0; br_valid = 1'b0;
    check("redir_rise", 32'(redir_valid), 1);
    check("redir_pc", redir_pc, tgt);
    check("fetch_kill", 32'(fetch_kill), 1);
    check("redir_busy", 32'(br_busy), 1);
    if (mode == 2) begin
      ex_flush = 1'b1; redir_ready = 1'b1;
      step();
      ex_flush = 1'b0; redir_ready = 1'b0;
      check("flush_rd_valid", 32'(redir_valid), 0);
      check("flush_rd_kill", 32'(fetch_kill), 0);
      check("flush_rd_busy", 32'(br_busy), 0);
      return;
    end
    for (int i = 0; i < rdy_lat; i++) begin
      step();
      check("bp_valid", 32'(redir_valid), 1);
      check("bp_busy", 32'(br_busy), 1);
    end
    redir_ready = 1'b1;
    step();
    redir_ready = 1'b0;
    check("done_valid", 32'(redir_valid), 0);
    check("done_kill", 32'(fetch_kill), 0);
    check("done_busy", 32'(br_busy), 0);
  endtask

  // A taken branch presented while stalled or flushed must be ignored.
  task automatic blocked_branch(input bit use_flush);
    br_valid = 1'b1; br_rs = 32'h5; br_rt = 32'h5; br_cond = 6'b000001;
    br_target = 32'h8000_2000;
    if (use_flush) ex_flush = 1'b1; else stall = 1'b1;
    step();
    br_valid = 1'b0; ex_flush = 1'b0; stall = 1'b0;
    check(use_flush ? "flush_br_busy" : "stall_br_busy", 32'(br_busy), 0);
    check("blocked_perf_br", perf_br, 32'(exp_br));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rs, rt, tgt;
    logic [5:0]  cond;
    int          r, mode;

    rst = 1'b1; br_valid = 1'b0; br_rs = '0; br_rt = '0; br_cond = '0; br_target = '0;
    ds_valid = 1'b0; stall = 1'b0; ex_flush = 1'b0; redir_ready = 1'b0;
    #1;
    check("rst_busy", 32'(br_busy), 0);
    check("rst_redir_valid", 32'(redir_valid), 0);
    check("rst_redir_pc", redir_pc, 0);
    check("rst_perf_br", perf_br, 0);
    check("rst_perf_taken", perf_taken, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // BEQ taken
    run_branch(32'h5, 32'h5, 6'b000001, 32'h8000_1000, 0, 0, 0);
    check("beq_perf_br", perf_br, 1);
    check("beq_perf_taken", perf_taken, 1);
    // BLTZ not taken
    run_branch(32'h1, 32'h0, 6'b100000, 32'h8000_1100, 0, 0, 0);
    check("bltz_perf_br", perf_br, 2);
    check("bltz_perf_taken", perf_taken, 1);
    // signed boundaries
    run_branch(32'h8000_0000, 32'h0, 6'b000100, 32'h8000_1200, 0, 0, 0);
    run_branch(32'h0, 32'h1, 6'b010000, 32'h8000_1300, 0, 0, 0);
    run_branch(32'h0, 32'h1, 6'b000100, 32'h8000_1400, 0, 0, 0);
    run_branch(32'h0, 32'h1, 6'b001000, 32'h8000_1500, 0, 0, 0);
    check("sgn_perf_taken", perf_taken, 3);
    // backpressure
    run_branch(32'h7, 32'h7, 6'b000001, 32'h8000_1600, 3, 2, 0);
    // flush in WAIT_DS and in REDIR
    run_branch(32'h7, 32'h7, 6'b000001, 32'h8000_1700, 0, 0, 1);
    run_branch(32'h7, 32'h7, 6'b000001, 32'h8000_1800, 1, 0, 2);
    // branch in delay slot
    run_branch(32'h1, 32'h2, 6'b000010, 32'h8000_1900, 0, 1, 3);
    check("ds_err_perf_br", perf_br, 32'(exp_br));
    blocked_branch(1'b1);
    blocked_branch(1'b0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: rs = 32'h0;
        1: rs = 32'h1;
        2: rs = 32'hffff_ffff;
        3: rs = 32'h8000_0000;
        4: rs = 32'h7fff_ffff;
        default: rs = $urandom;
      endcase
      rt = ($urandom_range(0, 1) == 1) ? rs : $urandom;
      case ($urandom_range(0, 3))
        0: cond = 6'(1 << $urandom_range(0, 5));
        1: cond = 6'b0;
        default: cond = 6'($urandom);
      endcase
      tgt = $urandom & 32'hffff_fffc;
      r = $urandom_range(0, 9);
      mode = (r < 6) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : 3;
      run_branch(rs, rt, cond, tgt, $urandom_range(0, 3), $urandom_range(0, 3), mode);
    end

    repeat (3) step();
    check("final_q_empty", 32'(exp_q.size()), 0);
    check("final_perf_br", perf_br, 32'(exp_br));
    check("final_perf_taken", perf_taken, 32'(exp_taken));
    check("final_ds_err_cnt", 32'(err_seen), 32'(exp_err));

    // async reset in REDIR, sampled before any clock edge
    br_valid = 1'b1; br_rs = 32'h3; br_rt = 32'h3; br_cond = 6'b000001; br_target = 32'h8000_3000;
    exp_q.push_back(32'h8000_3000);
    step();
    br_valid = 1'b0; ds_valid = 1'b1;
    step();
    ds_valid = 1'b0;
    check("pre_rst_valid", 32'(redir_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_redir_valid", 32'(redir_valid), 0);
    check("arst_redir_pc", redir_pc, 0);
    check("arst_fetch_kill", 32'(fetch_kill), 0);
    check("arst_busy", 32'(br_busy), 0);
    check("arst_perf_br", perf_br, 0);
    check("arst_perf_taken", perf_taken, 0);
    exp_q.delete();
    exp_br = 0; exp_taken = 0;
    @(posedge clk);
    #1 rst = 1'b0;

    run_branch(32'h9, 32'h9, 6'b000001, 32'h8000_4000, 0, 0, 0);
    check("post_rst_perf_br", perf_br, 1);
    check("post_rst_perf_taken", perf_taken, 1);
    check("post_rst_q_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/br_seq.md
Name: br_seq

Overview:
- Branch sequencer for the MIPS32 in-order core; sits between decode and fetch.
- Accepts a decoded branch with its operands and decides taken/not-taken through the condition sub-module.
- Waits for the architectural delay-slot instruction to be accepted, then issues a one-shot redirect to fetch and kills wrong-path fetches.
- Also handles exception flush, the branch-in-delay-slot error, and branch performance counters.

Parameters:
- ADDR_W, 32, PC/target width
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- br_valid  in  1  decode presents a branch this cycle
- br_rs  in  32  rs operand, already forwarded
- br_rt  in  32  rt operand, already forwarded
- br_cond  in  6  one-hot condition: {ltz, lez, gtz, gez, ne, eq}
- br_target  in  ADDR_W  computed branch target
- ds_valid  in  1  delay-slot instruction present in decode
- stall  in  1  decode stalled; nothing is accepted this cycle
- ex_flush  in  1  exception/ERET flush from commit
- redir_ready  in  1  fetch accepts the redirect
- br_busy  out  1  sequencer not IDLE; decode must hold further branches
- redir_valid  out  1  redirect request to fetch
- redir_pc  out  ADDR_W  redirect target
- fetch_kill  out  1  invalidate fetch-buffer entries younger than the delay slot
- ds_br_err  out  1  one-cycle pulse: branch presented in a delay slot
- perf_br  out  CNT_W  count of accepted branches
- perf_taken  out  CNT_W  count of taken branches

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; target register 0; counters 0.
- Acceptance: acc_br = br_valid & ~stall & ~ex_flush. acc_ds = ds_valid & ~stall & ~ex_flush.
- taken = (cond_vec & br_cond) != 0. Evaluated combinationally on the input operands in the acceptance cycle, then registered.
- cond_vec bits from MSB: rs<0, rs<=0, rs>0, rs>=0 (all signed 32-bit), rs!=rt, rs==rt.
- br_cond = 0 means never taken. Multiple bits set are ORed.
- States: IDLE, WAIT_DS, REDIR.
- IDLE:
  - On acc_br, perf_br increments.
  - If taken: perf_taken increments, target latched, next state WAIT_DS.
  - If not taken: stay IDLE; no fetch-side action.
- WAIT_DS:
  - On acc_ds, next state REDIR.
  - If br_valid is also high that cycle, pulse ds_br_err. The instruction is treated as the delay slot only; no counters update and it is not evaluated as a branch.
- REDIR:
  - redir_valid=1, redir_pc=latched target, fetch_kill=1 (registered outputs, valid from the first REDIR cycle).
  - Held stable until redir_ready, then the next state is IDLE and the outputs drop the following cycle.
  - Latency: redir_valid rises the cycle after delay-slot acceptance.
- br_busy = (state != IDLE).
- ex_flush, any state: next state IDLE, redir_valid/fetch_kill drop next cycle, latched branch discarded. It has priority over redir_ready and acc_ds in the same cycle. Counters keep prior values; a branch in the flush cycle is not counted.
- stall in WAIT_DS holds the state indefinitely. stall does not affect REDIR, since the fetch handshake is independent.
- Counters wrap modulo 2^CNT_W.

Decomposition:
- Shared package br_pkg: state encoding (IDLE=2'd0, WAIT_DS=2'd1, REDIR=2'd2); condition bit indices BR_EQ=0, BR_NE=1, BR_GEZ=2, BR_GTZ=3, BR_LEZ=4, BR_LTZ=5; width constants.
- Sub-module br_cond_eval: purely combinational; inputs rs, rt, cond; output taken. Instantiated once.

Test Plan:
- BEQ taken: rs=rt=0x5, cond=6'b000001, target=0x80001000. Next cycle ds_valid → redir_valid=1 with pc 0x80001000 one cycle later; with redir_ready=1, drops after one cycle; perf_br=1, perf_taken=1.
- BLTZ not taken: rs=0x00000001, cond=6'b100000 → state stays IDLE, redir_valid never rises, perf_br=1, perf_taken=0.
- Signed boundaries: rs=0x80000000 with BGEZ → not taken; rs=0 with BLEZ and with BGEZ → taken; rs=0 with BGTZ → not taken.
- Backpressure: taken branch, ds stalled 3 cycles, then accepted; redir_ready low 2 cycles → redir_valid/pc stable throughout; br_busy high from the branch cycle+1 until IDLE.
- Flush: taken branch, ex_flush asserted in the WAIT_DS cycle, then in a REDIR cycle with redir_ready=1 → IDLE next cycle, no redirect (WAIT_DS case), redir_valid drops (REDIR case).
- Branch in delay slot: taken BNE, then br_valid with ds_valid in WAIT_DS → ds_br_err single pulse, perf_br stays 1, redirect to the first target only.
- Async reset asserted mid-REDIR, no clock edge → all outputs 0 immediately.
